// File: rtl/ram_seq.sv
// Single-port data RAM for the accumulator processor: request/ack handshake,
// 1- or 2-cycle registered read, one-word-per-cycle clear sweep and a debug read port.
module ram_seq #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               enab,
  input  logic               rw,
  input  logic [A_WIDTH-1:0] addr,
  input  logic [D_WIDTH-1:0] data_in,
  output logic               ack,
  output logic [D_WIDTH-1:0] data_out,
  output logic               rd_valid,
  output logic               busy,
  input  logic [A_WIDTH-1:0] dbg_addr,
  output logic [D_WIDTH-1:0] dbg_data
);

  localparam int DEPTH = 1 << A_WIDTH;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;
  localparam logic [A_WIDTH-1:0] CNT_LAST = {A_WIDTH{1'b1}};
  localparam logic [A_WIDTH-1:0] CNT_ZERO = {A_WIDTH{1'b0}};
  localparam logic [A_WIDTH-1:0] CNT_ONE  = A_WIDTH'(1);
  localparam logic [D_WIDTH-1:0] D_ZERO   = {D_WIDTH{1'b0}};

  logic [D_WIDTH-1:0] mem_r [DEPTH];
  logic [0:0]         state_r;
  logic [A_WIDTH-1:0] cnt_r;
  logic               busy_r;
  logic               ack_r;
  logic               rd_valid_r;
  logic [D_WIDTH-1:0] data_out_r;
  logic [D_WIDTH-1:0] stage_data_r;
  logic               stage_vld_r;

  logic               accept_s;
  logic               rd_accept_s;
  logic               wr_accept_s;
  logic               sweep_s;

  // Request acceptance and sweep-write qualification; clr overrides everything.
  always_comb begin
    accept_s    = enab & ~clr & ~busy_r & (state_r == ST_IDLE);
    rd_accept_s = accept_s & ~rw;
    wr_accept_s = accept_s & rw;
    sweep_s     = ~clr & (state_r == ST_CLEAR);
  end

  // Sequencer: the terminal compare returns to IDLE so the counter never starts a second pass.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= ST_CLEAR;
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_CLEAR;
          cnt_r   <= CNT_ZERO;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Memory array write port, shared by the sweep and accepted writes.
  always_ff @(posedge clk) begin
    if (sweep_s) begin
      mem_r[cnt_r] <= D_ZERO;
    end else if (wr_accept_s) begin
      mem_r[addr] <= data_in;
    end
  end

  // Handshake and read pipeline; the optional stage adds one cycle when RD_LAT is 2.
  always_ff @(posedge clk) begin
    if (clr) begin
      ack_r        <= 1'b0;
      rd_valid_r   <= 1'b0;
      data_out_r   <= D_ZERO;
      stage_vld_r  <= 1'b0;
      stage_data_r <= D_ZERO;
    end else begin
      ack_r       <= accept_s;
      stage_vld_r <= rd_accept_s;
      if (rd_accept_s) begin
        stage_data_r <= mem_r[addr];
      end
      if (RD_LAT == 2) begin
        rd_valid_r <= stage_vld_r;
        if (stage_vld_r) begin
          data_out_r <= stage_data_r;
        end
      end else begin
        rd_valid_r <= rd_accept_s;
        if (rd_accept_s) begin
          data_out_r <= mem_r[addr];
        end
      end
    end
  end

  assign ack      = ack_r;
  assign rd_valid = rd_valid_r;
  assign data_out = data_out_r;
  assign busy     = busy_r;
  assign dbg_data = mem_r[dbg_addr];

endmodule

// File: tb/tb_ram_seq.sv
// Bench for ram_seq: two instances (RD_LAT 1 and 2) share stimulus; a reference
// model predicts busy/ack and queues expected read data with its due cycle.
module tb_ram_seq;

  logic       clk = 1'b0;
  logic       clr, enab, rw;
  logic [7:0] addr, data_in, dbg_addr;
  logic       ack1, rv1, busy1, ack2, rv2, busy2;
  logic [7:0] dout1, dbg1, dout2, dbg2;
  logic [7:0] exp_rd;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [7:0] data; int due; } rd_exp_t;
  rd_exp_t q1[$];
  rd_exp_t q2[$];

  typedef struct { logic rw; logic [7:0] addr; logic [7:0] wdata; logic [7:0] exp_data; } vec_t;
  localparam int NV = 17;
  vec_t vecs[NV];

  int cyc     = 0;
  bit started = 1'b0;
  bit busy_m  = 1'b0;
  int cnt_m   = 0;
  bit ack_exp = 1'b0;

  ram_seq #(.D_WIDTH(8), .A_WIDTH(8), .RD_LAT(1)) dut1 (
    .clk(clk), .clr(clr), .enab(enab), .rw(rw), .addr(addr), .data_in(data_in),
    .ack(ack1), .data_out(dout1), .rd_valid(rv1), .busy(busy1),
    .dbg_addr(dbg_addr), .dbg_data(dbg1)
  );

  ram_seq #(.D_WIDTH(8), .A_WIDTH(8), .RD_LAT(2)) dut2 (
    .clk(clk), .clr(clr), .enab(enab), .rw(rw), .addr(addr), .data_in(data_in),
    .ack(ack2), .data_out(dout2), .rd_valid(rv2), .busy(busy2),
    .dbg_addr(dbg_addr), .dbg_data(dbg2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, req);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual pulse/no pulse, required the opposite", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_sweep(input string name);
    int n;
    n = 0;
    while (busy1 && n < 300) begin
      n++;
      step();
    end
    check(name, n, 256);
  endtask

  // Reference model: busy/ack prediction and expected read queue, one entry per DUT.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    ack_exp <= 1'b0;
    if (clr) begin
      started <= 1'b1;
      busy_m  <= 1'b1;
      cnt_m   <= 0;
      q1.delete();
      q2.delete();
    end else if (started) begin
      if (busy_m) begin
        if (cnt_m == 255) busy_m <= 1'b0;
        cnt_m <= cnt_m + 1;
      end else if (enab) begin
        ack_exp <= 1'b1;
        if (!rw) begin
          q1.push_back('{exp_rd, cyc + 1});
          q2.push_back('{exp_rd, cyc + 2});
        end
      end
    end
  end

  // Per-cycle comparison of busy/ack and scoreboard of read results.
  always @(negedge clk) begin
    if (started) begin
      check("busy1", busy1, busy_m);
      check("busy2", busy2, busy_m);
      check("ack1", ack1, ack_exp);
      check("ack2", ack2, ack_exp);
      if (rv1) begin
        if (q1.size() == 0) note_fail("rd_valid1_unexpected");
        else begin
          check("rd_data1", dout1, q1[0].data);
          check("rd_cycle1", cyc, q1[0].due);
          q1.delete(0);
        end
      end else if (q1.size() > 0 && q1[0].due <= cyc) begin
        note_fail("rd_valid1_missing");
        q1.delete(0);
      end
      if (rv2) begin
        if (q2.size() == 0) note_fail("rd_valid2_unexpected");
        else begin
          check("rd_data2", dout2, q2[0].data);
          check("rd_cycle2", cyc, q2[0].due);
          q2.delete(0);
        end
      end else if (q2.size() > 0 && q2[0].due <= cyc) begin
        note_fail("rd_valid2_missing");
        q2.delete(0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual still running, required finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 8'h03, 8'hEF, 8'h00};
    vecs[1]  = '{1'b0, 8'h03, 8'h00, 8'hEF};
    vecs[2]  = '{1'b1, 8'h00, 8'h01, 8'h00};
    vecs[3]  = '{1'b1, 8'h01, 8'h7F, 8'h00};
    vecs[4]  = '{1'b1, 8'h02, 8'h18, 8'h00};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 8'h01};
    vecs[6]  = '{1'b0, 8'h01, 8'h00, 8'h7F};
    vecs[7]  = '{1'b0, 8'h02, 8'h00, 8'h18};
    vecs[8]  = '{1'b1, 8'h7F, 8'hA5, 8'h00};
    vecs[9]  = '{1'b1, 8'hFF, 8'h3C, 8'h00};
    vecs[10] = '{1'b0, 8'hFF, 8'h00, 8'h3C};
    vecs[11] = '{1'b1, 8'hFF, 8'hC3, 8'h00};
    vecs[12] = '{1'b0, 8'hFF, 8'h00, 8'hC3};
    vecs[13] = '{1'b1, 8'h10, 8'h99, 8'h00};
    vecs[14] = '{1'b0, 8'h7F, 8'h00, 8'hA5};
    vecs[15] = '{1'b0, 8'h10, 8'h00, 8'h99};
    vecs[16] = '{1'b0, 8'h03, 8'h00, 8'hEF};

    // Power-up clear with a read of 0x05 held through the sweep.
    clr = 1'b1; enab = 1'b1; rw = 1'b0; addr = 8'h05; data_in = 8'h00;
    exp_rd = 8'h00; dbg_addr = 8'h00;
    step();
    check("rst_busy1", busy1, 1);
    check("rst_busy2", busy2, 1);
    check("rst_ack1", ack1, 0);
    check("rst_rv1", rv1, 0);
    check("rst_rv2", rv2, 0);
    check("rst_dout1", dout1, 0);
    check("rst_dout2", dout2, 0);
    clr = 1'b0;
    count_sweep("sweep_len_init");
    check("blocked_no_ack_yet", ack1, 0);
    step();
    check("blocked_ack1", ack1, 1);
    check("blocked_ack2", ack2, 1);
    check("blocked_rv1", rv1, 1);
    check("blocked_dout1", dout1, 0);
    enab = 1'b0;
    step();
    check("blocked_rv2", rv2, 1);
    check("blocked_dout2", dout2, 0);

    // Back-to-back table, one request per cycle.
    for (int i = 0; i < NV; i++) begin
      enab = 1'b1; rw = vecs[i].rw; addr = vecs[i].addr;
      data_in = vecs[i].rw ? vecs[i].wdata : 8'h00;
      exp_rd = vecs[i].exp_data;
      step();
      check($sformatf("vec%0d_ack", i), ack1, 1);
    end
    enab = 1'b0;
    repeat (3) step();
    check("hold_dout1", dout1, 8'hEF);
    check("hold_dout2", dout2, 8'hEF);
    dbg_addr = 8'h03; #1;
    check("dbg_03", dbg1, 8'hEF);
    dbg_addr = 8'h7F; #1;
    check("dbg_7f", dbg2, 8'hA5);

    // Debug port sees a write the cycle after the write edge.
    dbg_addr = 8'h20; enab = 1'b1; rw = 1'b1; addr = 8'h20; data_in = 8'h5A;
    #1;
    check("dbg_pre_write", dbg1, 8'h00);
    step();
    enab = 1'b0;
    check("dbg_post_write1", dbg1, 8'h5A);
    check("dbg_post_write2", dbg2, 8'h5A);
    step();

    // clr the cycle after a read accept flushes the RD_LAT=2 pipeline.
    enab = 1'b1; rw = 1'b0; addr = 8'h10; exp_rd = 8'h99;
    step();
    check("midop_ack1", ack1, 1);
    check("midop_dout1", dout1, 8'h99);
    enab = 1'b0; clr = 1'b1;
    step();
    check("midop_rv2", rv2, 0);
    check("midop_dout2", dout2, 0);
    check("midop_dout1", dout1, 0);
    check("midop_busy2", busy2, 1);
    clr = 1'b0;
    count_sweep("sweep_len_midop");

    // Seed 0x06 and 0xFF, then clr together with a write to 0x06.
    enab = 1'b1; rw = 1'b1; addr = 8'h06; data_in = 8'h11;
    step();
    addr = 8'hFF; data_in = 8'hC3;
    step();
    clr = 1'b1; addr = 8'h06; data_in = 8'hDB;
    step();
    check("clrwr_ack1", ack1, 0);
    check("clrwr_ack2", ack2, 0);
    dbg_addr = 8'h06; #1;
    check("clrwr_no_write", dbg1, 8'h11);
    clr = 1'b0; enab = 1'b0;
    repeat (99) step();
    check("sweep_progress_06", dbg1, 8'h00);
    dbg_addr = 8'hFF; #1;
    check("sweep_progress_ff", dbg2, 8'hC3);

    // Re-assert clr mid-sweep; the sweep restarts in full.
    clr = 1'b1;
    step();
    clr = 1'b0;
    count_sweep("sweep_len_restart");
    dbg_addr = 8'h00; #1; check("dbg_00_clr", dbg1, 8'h00);
    dbg_addr = 8'h7F; #1; check("dbg_7f_clr", dbg1, 8'h00);
    dbg_addr = 8'hFF; #1; check("dbg_ff_clr", dbg2, 8'h00);
    dbg_addr = 8'h06; #1; check("dbg_06_clr", dbg1, 8'h00);

    enab = 1'b1; rw = 1'b0; addr = 8'h06; exp_rd = 8'h00;
    step();
    addr = 8'hFF;
    step();
    enab = 1'b0;
    repeat (3) step();
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
